mc_load_arbiter: RTL

- Memory-controller-side load stage directly downstream of the per-access load ports.
- Collects address requests from NUM_PORTS load ports, arbitrates them round-robin onto a single memory read-request channel, and tracks the port of every in-flight request.
- Routes returning in-order read data back to the issuing port through a MAX_INFLIGHT-deep completion buffer.

---
 rtl/mc_load_arb_pkg.sv | 21 ++
 rtl/mc_load_arbiter_rr_arbiter.sv | 31 +++
 rtl/mc_load_arbiter.sv | 144 ++++++++++++++
 3 files changed

// File: rtl/mc_load_arb_pkg.sv
// Shared helpers for the memory-controller load arbiter: width rules and slot layout constants.
package mc_load_arb_pkg;

  function automatic int unsigned clog2(input int unsigned value);
    int unsigned res;
    int unsigned span;
    res  = 0;
    span = 1;
    while (span < value) begin
      span = span << 1;
      res++;
    end
    return res;
  endfunction

  // Port ids need at least one bit even for a single port.
  function automatic int unsigned idWidth(input int unsigned numPorts);
    return (clog2(numPorts) > 0) ? clog2(numPorts) : 1;
  endfunction

endpackage

// File: rtl/mc_load_arbiter_rr_arbiter.sv
// Purely combinational round-robin arbiter: first requester at or after rrPtr wins, wrapping.
module rr_arbiter
  import mc_load_arb_pkg::*;
#(
  parameter int unsigned NUM_PORTS = 2,
  parameter int unsigned IdW       = idWidth(NUM_PORTS)
) (
  input  logic [NUM_PORTS-1:0] req,
  input  logic [IdW-1:0]       rrPtr,
  output logic [NUM_PORTS-1:0] grant,
  output logic [IdW-1:0]       grantId,
  output logic                 anyReq
);

  int unsigned idx;

  always_comb begin
    grant   = '0;
    grantId = '0;
    idx     = 0;
    for (int unsigned k = 0; k < NUM_PORTS; k++) begin
      idx = (int'(rrPtr) + k) % NUM_PORTS;
      if ((grant == '0) && req[idx]) begin
        grant[idx] = 1'b1;
        grantId    = IdW'(idx);
      end
    end
    anyReq = |req;
  end

endmodule

// File: rtl/mc_load_arbiter.sv
// Round-robin load arbiter with in-order completion buffer routing read data back to ports.
// Optional same-cycle memData-to-ldData forwarding when MC_LOAD_ARB_FALLTHROUGH_EN is defined.
module mc_load_arbiter
  import mc_load_arb_pkg::*;
#(
  parameter int unsigned NUM_PORTS    = 2,
  parameter int unsigned DATA_TYPE    = 32,
  parameter int unsigned ADDR_TYPE    = 32,
  parameter int unsigned MAX_INFLIGHT = 4
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic [NUM_PORTS*ADDR_TYPE-1:0] ldAddr,
  input  logic [NUM_PORTS-1:0]           ldAddr_valid,
  output logic [NUM_PORTS-1:0]           ldAddr_ready,
  output logic [NUM_PORTS*DATA_TYPE-1:0] ldData,
  output logic [NUM_PORTS-1:0]           ldData_valid,
  input  logic [NUM_PORTS-1:0]           ldData_ready,
  output logic [ADDR_TYPE-1:0]           memAddr,
  output logic                           memAddr_valid,
  input  logic                           memAddr_ready,
  input  logic [DATA_TYPE-1:0]           memData,
  input  logic                           memData_valid
);

  localparam int unsigned IdW  = idWidth(NUM_PORTS);
  localparam int unsigned PtrW = clog2(MAX_INFLIGHT);
  localparam int unsigned CntW = PtrW + 1;

  typedef struct packed {
    logic [IdW-1:0]       id;
    logic [DATA_TYPE-1:0] data;
    logic                 filled;
  } slot_t;

  slot_t           slots [MAX_INFLIGHT];
  logic [PtrW-1:0] issuePtr;
  logic [PtrW-1:0] fillPtr;
  logic [PtrW-1:0] headPtr;
  logic [CntW-1:0] count;
  logic [IdW-1:0]  rrPtr;

  logic [NUM_PORTS-1:0] grant;
  logic [IdW-1:0]       grantId;
  logic                 anyReq;

  rr_arbiter #(
    .NUM_PORTS(NUM_PORTS),
    .IdW      (IdW)
  ) u_rr_arbiter (
    .req    (ldAddr_valid),
    .rrPtr  (rrPtr),
    .grant  (grant),
    .grantId(grantId),
    .anyReq (anyReq)
  );

  slot_t                headSlot;
  logic                 credit;
  logic                 issueFire;
  logic                 hasUnfilled;
  logic                 fillFire;
  logic                 fillWrite;
  logic                 ftHit;
  logic                 ftConsume;
  logic                 deliverValid;
  logic                 deliverReady;
  logic                 deliverFire;
  logic [DATA_TYPE-1:0] deliverData;

  always_comb begin
    headSlot  = slots[headPtr];
    // Credit comes from registered count only, so a same-cycle deliver never frees a slot early.
    credit    = count < CntW'(MAX_INFLIGHT);
    issueFire = credit & anyReq & memAddr_ready;
    // fillPtr == issuePtr is ambiguous when full; the slot's filled bit disambiguates.
    hasUnfilled = (fillPtr != issuePtr) ||
                  ((count == CntW'(MAX_INFLIGHT)) && !slots[fillPtr].filled);
    fillFire  = memData_valid & hasUnfilled;
`ifdef MC_LOAD_ARB_FALLTHROUGH_EN
    ftHit       = fillFire && (fillPtr == headPtr) && !headSlot.filled;
    deliverData = ftHit ? memData : headSlot.data;
`else
    ftHit       = 1'b0;
    deliverData = headSlot.data;
`endif
    deliverValid = headSlot.filled | ftHit;
    deliverReady = ldData_ready[headSlot.id];
    deliverFire  = deliverValid & deliverReady;
    ftConsume    = ftHit & deliverReady;
    fillWrite    = fillFire & ~ftConsume;
    memAddr      = ldAddr[int'(grantId)*ADDR_TYPE +: ADDR_TYPE];
  end

  always_comb begin
    ldAddr_ready  = '0;
    memAddr_valid = 1'b0;
    ldData_valid  = '0;
    ldData        = '0;
    if (rst) begin
      memAddr_valid = credit & anyReq;
      if (credit && memAddr_ready) begin
        ldAddr_ready = grant;
      end
      if (deliverValid) begin
        ldData_valid[headSlot.id]                          = 1'b1;
        ldData[int'(headSlot.id)*DATA_TYPE +: DATA_TYPE] = deliverData;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      issuePtr <= '0;
      fillPtr  <= '0;
      headPtr  <= '0;
      count    <= '0;
      rrPtr    <= '0;
      for (int i = 0; i < int'(MAX_INFLIGHT); i++) begin
        slots[i].filled <= 1'b0;
      end
    end else begin
      if (issueFire) begin
        slots[issuePtr].id     <= grantId;
        slots[issuePtr].filled <= 1'b0;
        issuePtr               <= issuePtr + 1'b1;
        rrPtr                  <= (grantId == IdW'(NUM_PORTS - 1)) ? '0 : grantId + 1'b1;
      end
      if (fillWrite) begin
        slots[fillPtr].data   <= memData;
        slots[fillPtr].filled <= 1'b1;
      end
      if (fillFire) begin
        fillPtr <= fillPtr + 1'b1;
      end
      if (deliverFire) begin
        slots[headPtr].filled <= 1'b0;
        headPtr               <= headPtr + 1'b1;
      end
      count <= count + CntW'(issueFire) - CntW'(deliverFire);
    end
  end

endmodule
